// File: rtl/four_ch_distributor.sv
// Routes each accepted input word to one of four registered output channels,
// selected by {e0,e1} (fixed mode) or a rotating pointer (round-robin mode).
// Define DIST_CNT_EN to add the 8-bit xfer_cnt port counting accepted words.
module four_ch_distributor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             e0,
   input  logic             e1,
   input  logic             rr_mode,
   output logic [WIDTH-1:0] dout0,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3,
   output logic [3:0]       dout_valid,
   input  logic [3:0]       dout_ready,
   output logic [1:0]       rr_ptr,
`ifdef DIST_CNT_EN
   output logic [7:0]       xfer_cnt,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {ST_FIX, ST_RR, ST_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [1:0]       target;
   logic             xfer_in;
   logic [3:0]       valid_q;
   logic [WIDTH-1:0] data_q [4];

   // Target is taken from the current state, so a word accepted on a mode-change
   // edge is still routed under the old mode.
   always_comb begin
      target    = (state_q == ST_RR) ? rr_ptr_q : {e0, e1};
      din_ready = (state_q != ST_DRAIN) && (!valid_q[target] || dout_ready[target]);
      xfer_in   = din_valid && din_ready;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic             v_q, v_d;
         logic [WIDTH-1:0] d_q, d_d;

         always_comb begin
            v_d = v_q;
            d_d = d_q;
            if (xfer_in && (target == 2'(gi))) begin
               d_d = din;
               v_d = 1'b1;
            end else if (dout_ready[gi]) begin
               v_d = 1'b0;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               d_q <= '0;
            end else begin
               v_q <= v_d;
               d_q <= d_d;
            end
         end

         assign valid_q[gi] = v_q;
         assign data_q[gi]  = d_q;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_FIX: begin
            if (rr_mode) state_d = ST_DRAIN;
         end
         ST_RR: begin
            if (xfer_in) rr_ptr_d = rr_ptr_q + 2'd1;
            if (!rr_mode) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (valid_q == 4'b0000) begin
               state_d = rr_mode ? ST_RR : ST_FIX;
               if (rr_mode) rr_ptr_d = 2'd0;
            end
         end
         default: state_d = ST_FIX;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FIX;
         rr_ptr_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef DIST_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (xfer_in) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end

   assign xfer_cnt = cnt_q;
`endif

   assign dout0      = data_q[0];
   assign dout1      = data_q[1];
   assign dout2      = data_q[2];
   assign dout3      = data_q[3];
   assign dout_valid = valid_q;
   assign rr_ptr     = rr_ptr_q;
   assign busy       = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_four_ch_distributor.sv
// Directed bench for four_ch_distributor: behavioural model checked every cycle
// plus hand-computed literal expectations for the documented scenarios.
module tb_four_ch_distributor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] din = 4'h0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic       e0 = 1'b0;
   logic       e1 = 1'b0;
   logic       rr_mode = 1'b0;
   logic [3:0] dout0, dout1, dout2, dout3;
   logic [3:0] dout_valid;
   logic [3:0] dout_ready = 4'h0;
   logic [1:0] rr_ptr;
   logic       busy;
`ifdef DIST_CNT_EN
   logic [7:0] xfer_cnt;
`endif

   four_ch_distributor #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .e0         (e0),
      .e1         (e1),
      .rr_mode    (rr_mode),
      .dout0      (dout0),
      .dout1      (dout1),
      .dout2      (dout2),
      .dout3      (dout3),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .rr_ptr     (rr_ptr),
`ifdef DIST_CNT_EN
      .xfer_cnt   (xfer_cnt),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [3:0] dout_arr [4];
   assign dout_arr[0] = dout0;
   assign dout_arr[1] = dout1;
   assign dout_arr[2] = dout2;
   assign dout_arr[3] = dout3;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 = fixed, 1 = round-robin, 2 = draining.
   int         m_mode = 0;
   int         m_ptr  = 0;
   int         m_cnt  = 0;
   logic [3:0] m_data [4] = '{default: 4'h0};
   logic       m_valid [4] = '{default: 1'b0};

   function automatic int m_target();
      return (m_mode == 1) ? m_ptr : int'({e0, e1});
   endfunction

   function automatic logic m_ready();
      int t;
      t = m_target();
      return (m_mode != 2) && (!m_valid[t] || dout_ready[t]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int   t;
      logic acc;
      logic empty;
      if (!rst_n) begin
         m_mode = 0;
         m_ptr  = 0;
         m_cnt  = 0;
         for (int k = 0; k < 4; k++) begin
            m_data[k]  = 4'h0;
            m_valid[k] = 1'b0;
         end
      end else begin
         t     = m_target();
         acc   = din_valid && m_ready();
         empty = !(m_valid[0] || m_valid[1] || m_valid[2] || m_valid[3]);
         for (int k = 0; k < 4; k++) begin
            if (acc && k == t) begin
               m_data[k]  = din;
               m_valid[k] = 1'b1;
            end else if (dout_ready[k]) begin
               m_valid[k] = 1'b0;
            end
         end
         if (acc) m_cnt = (m_cnt + 1) % 256;
         if (m_mode == 0) begin
            if (rr_mode) m_mode = 2;
         end else if (m_mode == 1) begin
            if (acc) m_ptr = (m_ptr + 1) % 4;
            if (!rr_mode) m_mode = 2;
         end else if (empty) begin
            m_mode = rr_mode ? 1 : 0;
            if (rr_mode) m_ptr = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("din_ready", 32'(din_ready), 32'(m_ready()));
      chk("busy", 32'(busy), 32'(m_mode == 2));
      chk("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("dout_valid%0d", k), 32'(dout_valid[k]), 32'(m_valid[k]));
         chk($sformatf("dout%0d", k), 32'(dout_arr[k]), 32'(m_data[k]));
      end
`ifdef DIST_CNT_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
   end

   int ch1_del = 0;
   always @(posedge clk) begin
      if (rst_n && dout_valid[1] && dout_ready[1]) ch1_del++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int exp_ptr [6] = '{0, 1, 2, 3, 0, 1};
   int del_before;

   initial begin
      #1 rst_n = 1'b0;
      #11 rst_n = 1'b1;
      #1;
      chk("rst_din_ready", 32'(din_ready), 32'h1);
      chk("rst_dout_valid", 32'(dout_valid), 32'h0);
      chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // Fixed select {e0,e1}=10 -> ch2, then a second word to the full ch2.
      e0 = 1'b1; e1 = 1'b0; din = 4'hA; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      chk("fix_dout2", 32'(dout2), 32'hA);
      chk("fix_valid", 32'(dout_valid), 32'h4);
      din = 4'hB; din_valid = 1'b1;
      #1 chk("fix_full_ready", 32'(din_ready), 32'h0);
      din_valid = 1'b0;
      $display("T1 fixed route to ch2 done");

      // Replace-on-drain of ch1.
      e0 = 1'b0; e1 = 1'b1; din = 4'h3; din_valid = 1'b1;
      step();
      din = 4'h7; dout_ready = 4'b0010;
      del_before = ch1_del;
      #1 chk("ch1_pass_ready", 32'(din_ready), 32'h1);
      step();
      din_valid = 1'b0; dout_ready = 4'h0;
      chk("ch1_new_word", 32'(dout1), 32'h7);
      chk("ch1_still_valid", 32'(dout_valid[1]), 32'h1);
      chk("ch1_delivered", 32'(ch1_del - del_before), 32'h1);
      dout_ready = 4'hF;
      step();
      dout_ready = 4'h0;
      chk("all_drained", 32'(dout_valid), 32'h0);
      $display("T2 ch1 simultaneous in/out done");

      // Fill ch0 and ch3, then switch to round-robin through DRAIN.
      e0 = 1'b0; e1 = 1'b0; din = 4'h1; din_valid = 1'b1;
      step();
      e0 = 1'b1; e1 = 1'b1; din = 4'h2;
      step();
      din_valid = 1'b0;
      chk("pre_drain_valid", 32'(dout_valid), 32'h9);
      rr_mode = 1'b1;
      step();
      chk("drain_busy", 32'(busy), 32'h1);
      din_valid = 1'b1;
      #1 chk("drain_ready", 32'(din_ready), 32'h0);
      din_valid = 1'b0;
      step();
      chk("drain_hold_valid", 32'(dout_valid), 32'h9);
      dout_ready = 4'b0001;
      step();
      chk("drain_ch0_out", 32'(dout_valid), 32'h8);
      chk("drain_busy2", 32'(busy), 32'h1);
      dout_ready = 4'b1000;
      step();
      chk("drain_empty", 32'(dout_valid), 32'h0);
      chk("drain_busy3", 32'(busy), 32'h1);
      dout_ready = 4'h0;
      step();
      chk("rr_entry_busy", 32'(busy), 32'h0);
      chk("rr_entry_ptr", 32'(rr_ptr), 32'h0);
      $display("T3 fix->drain->rr done");

      // Round-robin: five words 1..5 with all consumers ready.
      dout_ready = 4'hF;
      for (int i = 0; i < 5; i++) begin
         chk("rr_ptr_seq", 32'(rr_ptr), 32'(exp_ptr[i]));
         din = 4'(i + 1); din_valid = 1'b1;
         step();
         chk("rr_word", 32'(dout_arr[i % 4]), 32'(i + 1));
         $display("T4 rr word %0d to ch%0d", i + 1, i % 4);
      end
      din_valid = 1'b0;
      chk("rr_ptr_seq", 32'(rr_ptr), 32'(exp_ptr[5]));
      step();
      dout_ready = 4'h0;

      // Word accepted on the RR->DRAIN edge, rr_mode toggled back during DRAIN.
      din = 4'h9; din_valid = 1'b1; rr_mode = 1'b0;
      step();
      din_valid = 1'b0;
      chk("old_mode_dout1", 32'(dout1), 32'h9);
      chk("old_mode_valid", 32'(dout_valid), 32'h2);
      chk("old_mode_busy", 32'(busy), 32'h1);
      chk("old_mode_ptr", 32'(rr_ptr), 32'h2);
      rr_mode = 1'b1; dout_ready = 4'b0010;
      step();
      chk("toggle_busy", 32'(busy), 32'h1);
      dout_ready = 4'h0;
      step();
      chk("toggle_exit_busy", 32'(busy), 32'h0);
      chk("toggle_exit_ptr", 32'(rr_ptr), 32'h0);
      $display("T5 rr->drain->rr done");

      // Three channels full, asynchronous reset between edges.
      for (int i = 0; i < 3; i++) begin
         din = 4'(12 + i); din_valid = 1'b1;
         step();
      end
      din_valid = 1'b0;
      chk("pre_rst_valid", 32'(dout_valid), 32'h7);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(dout_valid), 32'h0);
      chk("arst_dout0", 32'(dout0), 32'h0);
      chk("arst_dout1", 32'(dout1), 32'h0);
      chk("arst_dout2", 32'(dout2), 32'h0);
      chk("arst_ptr", 32'(rr_ptr), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_ready", 32'(din_ready), 32'h1);
      rr_mode = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      $display("T6 async reset done");

      // 257 accepted words into ch0.
      e0 = 1'b0; e1 = 1'b0; dout_ready = 4'hF; din_valid = 1'b1;
      for (int i = 0; i < 257; i++) begin
         din = 4'((i + 3) & 15);
         step();
      end
      din_valid = 1'b0;
      chk("burst_last_word", 32'(dout0), 32'h3);
`ifdef DIST_CNT_EN
      chk("xfer_cnt_wrap", 32'(xfer_cnt), 32'h1);
`endif
      $display("T7 257-word burst done");

      // Mixed traffic with partial readiness and a mode change midway.
      for (int i = 0; i < 60; i++) begin
         din_valid  = (i % 4) != 3;
         din        = 4'(i);
         e0         = ((i >> 2) & 1) != 0;
         e1         = ((i >> 3) & 1) != 0;
         dout_ready = 4'((i * 5) & 15);
         rr_mode    = (i >= 30);
         step();
      end
      din_valid = 1'b0; dout_ready = 4'hF;
      for (int i = 0; i < 4; i++) step();
      chk("final_empty", 32'(dout_valid), 32'h0);
      $display("T8 mixed traffic done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
